// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline-stage register: stage state
// encoding, default field width and field positions within a stage word.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   localparam int unsigned FIELD_W = 32'd32;

   localparam int unsigned F_INSTR = 32'd0;
   localparam int unsigned F_PC    = 32'd1;
   localparam int unsigned F_C     = 32'd2;
   localparam int unsigned F_RD    = 32'd3;
   localparam int unsigned F_EXT   = 32'd4;
   localparam int unsigned F_HILO  = 32'd5;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// One valid/ready channel carrying NFIELDS packed W-bit fields.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_skid_if #(
   parameter int unsigned NFIELDS = 32'd6,
   parameter int unsigned W       = 32'd32
);
   logic                   valid;
   logic                   ready;
   logic [NFIELDS*W-1:0]   data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One storage slot of the stage: a valid bit and a data word. Clearing the
// slot also zeroes the data, so an empty slot always holds a nop.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned NFIELDS = 32'd6,
   parameter int unsigned W       = FIELD_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 clear,
   input  logic [NFIELDS*W-1:0] d,
   output logic                 valid,
   output logic [NFIELDS*W-1:0] q
);

   logic                 valid_r;
   logic [NFIELDS*W-1:0] data_r;

   // Slot register; clear wins over load.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid_r <= 1'b0;
         data_r  <= {(NFIELDS*W){1'b0}};
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= d;
      end else begin
         valid_r <= valid_r;
         data_r  <= data_r;
      end
   end

   assign valid = valid_r;
   assign q     = data_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with an optional two-entry skid buffer,
// flush-to-bubble and all-zero data whenever the stage presents no beat.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned NFIELDS = 32'd6,
   parameter int unsigned W       = FIELD_W,
   parameter int unsigned SKID    = 32'd1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   pipe_stage_skid_if.slave          in_if,
   pipe_stage_skid_if.master         out_if,
   output logic [1:0]                occupancy
);

   stage_state_e         state_r;
   stage_state_e         state_next_s;
   logic                 in_ready_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 main_load_s;
   logic                 main_clear_s;
   logic [NFIELDS*W-1:0] main_d_s;
   logic                 main_valid_s;
   logic [NFIELDS*W-1:0] main_q_s;
   logic                 skid_load_s;
   logic                 skid_clear_s;
   logic                 skid_valid_s;
   logic [NFIELDS*W-1:0] skid_q_s;

   // With a skid slot, ready depends only on the state register, which breaks
   // the combinational ready path back from downstream.
   generate
      if (SKID != 32'd0) begin : g_ready_skid
         assign in_ready_s = (state_r != ST_FULL);
      end else begin : g_ready_single
         assign in_ready_s = !main_valid_s || out_if.ready;
      end
   endgenerate

   assign push_s = in_if.valid && in_ready_s;
   assign pop_s  = main_valid_s && out_if.ready;

   // Stage state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and slot control; flush overrides every handshake outcome.
   always_comb begin
      state_next_s = state_r;
      main_load_s  = 1'b0;
      main_clear_s = 1'b0;
      main_d_s     = in_if.data;
      skid_load_s  = 1'b0;
      skid_clear_s = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (push_s) begin
               main_load_s  = 1'b1;
               state_next_s = ST_ONE;
            end else begin
               state_next_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (push_s && pop_s) begin
               main_load_s  = 1'b1;
               state_next_s = ST_ONE;
            end else if (push_s) begin
               skid_load_s  = 1'b1;
               state_next_s = ST_FULL;
            end else if (pop_s) begin
               main_clear_s = 1'b1;
               state_next_s = ST_EMPTY;
            end else begin
               state_next_s = ST_ONE;
            end
         end
         ST_FULL: begin
            if (pop_s) begin
               main_load_s  = 1'b1;
               main_d_s     = skid_q_s;
               skid_clear_s = 1'b1;
               state_next_s = ST_ONE;
            end else begin
               state_next_s = ST_FULL;
            end
         end
         default: begin
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
            state_next_s = ST_EMPTY;
         end
      endcase
      if (flush) begin
         main_load_s  = 1'b0;
         skid_load_s  = 1'b0;
         main_clear_s = 1'b1;
         skid_clear_s = 1'b1;
         state_next_s = ST_EMPTY;
      end else begin
         state_next_s = state_next_s;
      end
   end

   pipe_slot #(.NFIELDS(NFIELDS), .W(W)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load_s),
      .clear (main_clear_s),
      .d     (main_d_s),
      .valid (main_valid_s),
      .q     (main_q_s)
   );

   generate
      if (SKID != 32'd0) begin : g_skid
         pipe_slot #(.NFIELDS(NFIELDS), .W(W)) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_load_s),
            .clear (skid_clear_s),
            .d     (in_if.data),
            .valid (skid_valid_s),
            .q     (skid_q_s)
         );
      end else begin : g_no_skid
         assign skid_valid_s = 1'b0;
         assign skid_q_s     = {(NFIELDS*W){1'b0}};
      end
   endgenerate

   assign in_if.ready  = in_ready_s;
   assign out_if.valid = main_valid_s;
   assign out_if.data  = main_q_s;
   // The skid slot is only ever valid together with the main slot.
   assign occupancy    = {skid_valid_s, main_valid_s & ~skid_valid_s};

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline-stage register for the five-stage CPU. It replaces the fixed per-stage registers (F/D, D/E, E/M, M/W) with one block that carries NFIELDS packed 32-bit fields. It uses a valid/ready handshake, optional two-entry skid buffering, flush-to-bubble, and a guarantee that an empty stage always presents all-zero data (instruction 0 = nop). Upstream and downstream can stall independently without combinational ready paths, which the single write-enable design could not do.

## Interface
- NFIELDS, 6: number of fields carried (instr, pc, alu result, mem data, ext, hilo …).
- W, 32: width of each field.
- SKID, 1: 1 = two-entry skid (registered in_ready); 0 = single entry, combinational in_ready.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clock clk.
- flush  in  1  discard all held entries (branch/exception kill).
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage accepts in_data this cycle.
- in_data  in  NFIELDS*W  packed fields; field k = bits [k*W +: W].
- out_valid  out  1  out_data holds a live instruction.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  NFIELDS*W  head entry; all zero when out_valid=0.
- occupancy  out  2  entries held (0..2; never exceeds 1 when SKID=0).

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Storage: main slot (drives out_data) and skid slot (SKID=1 only), each holds a valid bit and data.
- States (SKID=1): EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
  - EMPTY: accept → ONE, data goes to main.
  - ONE: accept without pop → FULL, data goes to skid. Pop without accept → EMPTY. Accept and pop → ONE, main takes in_data.
  - FULL: pop → ONE, skid moves to main and skid clears. No accept occurs, because in_ready=0.
- in_ready (SKID=1) = state != FULL. It is a registered function of state and has no dependency on out_ready.
- SKID=0: only EMPTY/ONE exist; in_ready = !out_valid || out_ready. Accept and pop in the same cycle replaces main.
- Bubble rule: whenever a slot becomes invalid (pop, flush, reset), its data is written to 0. out_data == 0 whenever out_valid == 0.
- Flush: next state EMPTY, both slots zeroed. A flush has priority over a simultaneous accept or pop: the incoming beat is dropped and the outgoing beat still counts as consumed by downstream in that cycle.
- reset has priority over flush. Reset is equivalent to flush and additionally applies regardless of handshake.
- Order is strict FIFO; data is never duplicated or reordered.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0. in_ready=1 from the first cycle after reset.
- Latency: one cycle from accept to out_valid in the EMPTY state; throughput one beat per cycle when out_ready is held high.
- in_ready drops the cycle after the stage enters FULL and rises the cycle after the first pop from FULL.
- Flush or reset asserted in cycle n: from cycle n+1, out_valid=0, out_data=0, in_ready=1.
- Reset or flush asserted mid-stall (FULL, out_ready=0) discards both entries with no pop.

## Structure
- Package pipe_pkg holds:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - the default field width 32;
  - field index constants (F_INSTR=0, F_PC=1, F_C=2, F_RD=3, F_EXT=4, F_HILO=5).
- One sub-module, pipe_slot: a valid bit plus NFIELDS*W data register, with load and clear-to-zero controls. It is instantiated once for main and once for skid (generate on SKID).

## Test plan
- Reset then idle: out_valid=0, out_data=0, in_ready=1, occupancy=0 for 10 cycles.
- Stream with SKID=1 and out_ready=1: push instr 0x2402000A… (pc 0x3000, 0x3004, …) every cycle → each beat appears one cycle later, in order, no gaps.
- Stall: push A, B with out_ready=0 → occupancy=2, in_ready=0. Raise out_ready → A then B on consecutive cycles, and in_ready=1 the cycle after A pops.
- Flush in FULL with a simultaneous in_valid beat C → next cycle out_valid=0, out_data=0. C never appears.
- SKID=0: out_ready=0 with main held gives in_ready=0 in the same cycle. Accept and pop in one cycle replaces main with no bubble.
- Reset asserted while FULL and flush also high → all outputs zero next cycle, with in_ready=1 and no pop observed downstream.
